// File: rtl/hazard_stall_unit.sv
// ID-stage hazard controller: load-use stalls, branch flush of IF/ID, and pipe freeze on memory busy.
// Define STALL_STATS_EN to build the saturating stall/flush statistics counters.
module hazard_stall_unit #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] IF_ID_Rs,
  input  logic [REG_ADDR_W-1:0] IF_ID_Rt,
  input  logic                  ID_uses_Rs,
  input  logic                  ID_uses_Rt,
  input  logic                  ID_EX_MemRead,
  input  logic [REG_ADDR_W-1:0] ID_EX_Write_register,
  input  logic                  EX_MEM_MemRead,
  input  logic [REG_ADDR_W-1:0] EX_MEM_Write_register,
  input  logic                  ID_Branch_Taken,
  input  logic                  Mem_Busy,
  output logic                  PC_Write,
  output logic                  IF_ID_Write,
  output logic                  IF_ID_Flush,
  output logic                  ID_EX_Bubble,
  output logic                  Pipe_Freeze,
  output logic [CNT_W-1:0]      Load_Stall_Count,
  output logic [CNT_W-1:0]      Flush_Count
);

  typedef enum logic {StRun, StHold1} state_e;

  state_e state_q, state_d;
  logic   dep_ex, dep_mem, haz_ex, haz_mem;

  assign dep_ex = (ID_EX_Write_register != '0) &&
                  ((ID_EX_Write_register == IF_ID_Rs && ID_uses_Rs) ||
                   (ID_EX_Write_register == IF_ID_Rt && ID_uses_Rt));
  assign dep_mem = (EX_MEM_Write_register != '0) &&
                   ((EX_MEM_Write_register == IF_ID_Rs && ID_uses_Rs) ||
                    (EX_MEM_Write_register == IF_ID_Rt && ID_uses_Rt));
  assign haz_ex  = ID_EX_MemRead && dep_ex;
  assign haz_mem = EX_MEM_MemRead && dep_mem;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    PC_Write     = 1'b0;
    IF_ID_Write  = 1'b0;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b0;
    Pipe_Freeze  = 1'b0;
    // Outputs are forced quiet while reset is held, regardless of state.
    if (reset) begin
      unique case (state_q)
        StRun: begin
          if (Mem_Busy) begin
            Pipe_Freeze = 1'b1;
          end else if (haz_ex) begin
            ID_EX_Bubble = 1'b1;
            state_d      = StHold1;
          end else if (haz_mem) begin
            ID_EX_Bubble = 1'b1;
          end else begin
            PC_Write    = 1'b1;
            IF_ID_Write = 1'b1;
            IF_ID_Flush = ID_Branch_Taken;
          end
        end
        StHold1: begin
          if (Mem_Busy) begin
            Pipe_Freeze = 1'b1;
          end else begin
            ID_EX_Bubble = 1'b1;
            state_d      = StRun;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

`ifdef STALL_STATS_EN
  logic [CNT_W-1:0] load_stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_stall_cnt_q <= '0;
      flush_cnt_q      <= '0;
    end else begin
      if (ID_EX_Bubble && load_stall_cnt_q != '1) begin
        load_stall_cnt_q <= load_stall_cnt_q + CNT_W'(1);
      end
      if (IF_ID_Flush && flush_cnt_q != '1) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign Load_Stall_Count = load_stall_cnt_q;
  assign Flush_Count      = flush_cnt_q;
`else
  assign Load_Stall_Count = '0;
  assign Flush_Count      = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: expected control vectors are queued when inputs are
// driven and compared at the following falling edge.
module tb_hazard_stall_unit;

  localparam int unsigned RW = 5;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [RW-1:0] rs, rt, exw, memw;
  logic          urs, urt, exr, memr, br, busy;
  logic          pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze;
  logic [CW-1:0] load_stall_count, flush_count;

  hazard_stall_unit #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .IF_ID_Rs              (rs),
    .IF_ID_Rt              (rt),
    .ID_uses_Rs            (urs),
    .ID_uses_Rt            (urt),
    .ID_EX_MemRead         (exr),
    .ID_EX_Write_register  (exw),
    .EX_MEM_MemRead        (memr),
    .EX_MEM_Write_register (memw),
    .ID_Branch_Taken       (br),
    .Mem_Busy              (busy),
    .PC_Write              (pc_write),
    .IF_ID_Write           (if_id_write),
    .IF_ID_Flush           (if_id_flush),
    .ID_EX_Bubble          (id_ex_bubble),
    .Pipe_Freeze           (pipe_freeze),
    .Load_Stall_Count      (load_stall_count),
    .Flush_Count           (flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         tag;
    logic [4:0]    ctl;  // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Pipe_Freeze}
    logic [CW-1:0] lsc;
    logic [CW-1:0] fc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state
  bit            m_hold;
  logic [CW-1:0] m_lsc, m_fc;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic compare_front();
    exp_t e;
    if (sb.size() == 0) begin
      check_val("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check_val({e.tag, ".ctl"},
                {27'd0, pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze},
                {27'd0, e.ctl});
      check_val({e.tag, ".lsc"}, 32'(load_stall_count), 32'(e.lsc));
      check_val({e.tag, ".fc"}, 32'(flush_count), 32'(e.fc));
    end
  endtask

  function automatic bit dep(input logic [RW-1:0] r);
    return (r != 0) && ((r == rs && urs) || (r == rt && urt));
  endfunction

  task automatic push_zero(input string tag);
    exp_t e;
    e.tag = tag; e.ctl = 5'b00000; e.lsc = '0; e.fc = '0;
    sb.push_back(e);
  endtask

  // One clock of stimulus: drive, predict, compare before the edge, advance the model.
  task automatic cyc(input string tag, input logic [RW-1:0] a_rs, input logic [RW-1:0] a_rt,
                     input logic a_urs, input logic a_urt, input logic a_exr,
                     input logic [RW-1:0] a_exw, input logic a_memr, input logic [RW-1:0] a_memw,
                     input logic a_br, input logic a_busy);
    exp_t e;
    bit   nxt_hold, stall, flush;
    rs = a_rs; rt = a_rt; urs = a_urs; urt = a_urt; exr = a_exr; exw = a_exw;
    memr = a_memr; memw = a_memw; br = a_br; busy = a_busy;
    nxt_hold = m_hold; stall = 0; flush = 0;
    if (busy) begin
      e.ctl = 5'b00001;
    end else if (m_hold || (exr && dep(exw)) || (memr && dep(memw))) begin
      e.ctl = 5'b00010; stall = 1;
      nxt_hold = !m_hold && exr && dep(exw);
    end else if (br) begin
      e.ctl = 5'b11100; flush = 1;
    end else begin
      e.ctl = 5'b11000;
    end
    e.tag = tag;
`ifdef STALL_STATS_EN
    e.lsc = m_lsc; e.fc = m_fc;
`else
    e.lsc = '0; e.fc = '0;
`endif
    sb.push_back(e);
    @(negedge clk);
    compare_front();
    @(posedge clk);
    m_hold = nxt_hold;
    if (stall && m_lsc != '1) m_lsc = m_lsc + 1'b1;
    if (flush && m_fc != '1) m_fc = m_fc + 1'b1;
    #1;
  endtask

  task automatic idle(input string tag);
    cyc(tag, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd1, 1'b0, 5'd2, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    rs = '0; rt = '0; exw = '0; memw = '0;
    urs = 0; urt = 0; exr = 0; memr = 0; br = 0; busy = 0;
    m_hold = 0; m_lsc = '0; m_fc = '0;
    #1;
    push_zero("reset");
    compare_front();
    @(posedge clk); #1;
    reset = 1'b1;

    idle("idle0");
    // lw $8 in EX, ID reads $8 via Rs: two stall cycles
    cyc("lw_ex_1", 5'd8, 5'd3, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 1'b0);
    cyc("lw_ex_2", 5'd8, 5'd3, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0, 1'b0);
    cyc("lw_ex_3", 5'd8, 5'd3, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    // lw $8 in MEM only, ID reads $8 via Rt: one stall
    cyc("lw_mem_1", 5'd4, 5'd8, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0, 1'b0);
    cyc("lw_mem_2", 5'd4, 5'd8, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    // register 0 and non-load producers never stall; unused operand never stalls
    cyc("lw_r0", 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    cyc("alu_ex", 5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0, 5'd9, 1'b0, 1'b0);
    cyc("unused", 5'd9, 5'd7, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0);
    // taken branch flushes; branch under a hazard is ignored
    cyc("beq", 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    cyc("beq_haz", 5'd5, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0);
    cyc("beq_busy", 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    cyc("beq_again", 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    // Mem_Busy for 3 cycles in HOLD1
    cyc("hold_enter", 5'd6, 5'd0, 1'b1, 1'b0, 1'b1, 5'd6, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc($sformatf("hold_busy%0d", i), 5'd6, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd6,
          1'b0, 1'b1);
    end
    cyc("hold_stall", 5'd6, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd6, 1'b0, 1'b0);
    idle("hold_run");

    // Reset asserted mid-HOLD1: outputs drop at once, no residual stall afterwards
    cyc("rst_enter", 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 1'b0);
    reset = 1'b0;
    m_hold = 0; m_lsc = '0; m_fc = '0;
    #1;
    push_zero("rst_async");
    compare_front();
    @(negedge clk);
    push_zero("rst_held");
    compare_front();
    @(posedge clk); #1;
    reset = 1'b1;
    idle("rst_release");

    // Counter saturation
    for (int i = 0; i < 20; i++) begin
      cyc($sformatf("sat_stall%0d", i), 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd3,
          1'b0, 1'b0);
    end
    for (int i = 0; i < 20; i++) begin
      cyc($sformatf("sat_flush%0d", i), 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0,
          1'b1, 1'b0);
    end

    // Random traffic over a small register range to hit hazards often
    for (int i = 0; i < 200; i++) begin
      cyc($sformatf("rnd%0d", i), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
          1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
          1'($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
